// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable integer clock divider.
// Each channel divides clk by its own ratio and produces a registered divided
// clock, a one-cycle enable pulse at the start of every output period, and a
// one-cycle pulse when a newly sampled divisor becomes the active one.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   en_i    per-channel enable
//   sync_i  single-cycle pulse restarting every enabled channel together
//   div_i   per-channel divisor, channel n at [n*DIV_W +: DIV_W]; 0 acts as 1
//   clk_o   registered divided clock per channel (high floor(D/2), low ceil(D/2))
//   ce_o    one-cycle pulse at the start of each output period
//   upd_o   one-cycle pulse when a changed divisor takes effect
module clk_div_prog #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    sync_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [NUM_CH-1:0]       upd_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] deff;
    logic [DIV_W-1:0] dact_q, dact_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             en_q;
    logic             clk_q, clk_d;
    logic             ce_q, ce_d;
    logic             upd_q, upd_d;
    logic             wrap;

    always_comb begin
      deff = div_i[g*DIV_W +: DIV_W];
      if (deff == '0) deff = DIV_W'(1);
    end

    assign wrap = (cnt_q == dact_q - 1'b1) || sync_i;

    always_comb begin
      dact_d = dact_q;
      cnt_d  = cnt_q;
      clk_d  = 1'b0;
      ce_d   = 1'b0;
      upd_d  = 1'b0;
      if (!en_i[g]) begin
        // Park one step before the wrap so the first enabled edge starts a period.
        dact_d = deff;
        cnt_d  = deff - 1'b1;
      end else if (wrap) begin
        dact_d = deff;
        cnt_d  = '0;
        ce_d   = 1'b1;
        upd_d  = (deff != dact_q) && en_q;
        clk_d  = cnt_d < (dact_d >> 1);
      end else begin
        cnt_d  = cnt_q + 1'b1;
        clk_d  = cnt_d < (dact_d >> 1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dact_q <= DIV_W'(1);
        cnt_q  <= '0;
        en_q   <= 1'b0;
        clk_q  <= 1'b0;
        ce_q   <= 1'b0;
        upd_q  <= 1'b0;
      end else begin
        dact_q <= dact_d;
        cnt_q  <= cnt_d;
        en_q   <= en_i[g];
        clk_q  <= clk_d;
        ce_q   <= ce_d;
        upd_q  <= upd_d;
      end
    end

    assign clk_o[g] = clk_q;
    assign ce_o[g]  = ce_q;
    assign upd_o[g] = upd_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       en_i = '0;
  logic                    sync_i = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div_i = '0;
  logic [NUM_CH-1:0]       clk_o, ce_o, upd_o;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_prog #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .sync_i(sync_i),
    .div_i(div_i), .clk_o(clk_o), .ce_o(ce_o), .upd_o(upd_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int ch, input int v);
    logic [DIV_W-1:0] vv;
    vv = v[DIV_W-1:0];
    div_i[ch*DIV_W +: DIV_W] = vv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_i = '0; sync_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) set_div(c, 5);
    #22;
    @(negedge clk); rst_n = 1'b1;
    en_i[0] = 1'b1;
    for (int k = 0; k < 6; k++) step();
    n_tests++;
    if (clk_o[0] !== 1'b1 || ce_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_precount: clk_o=%b ce_o=%b required clk_o[0]=1 ce_o[0]=1", clk_o, ce_o);
    end
    @(negedge clk); rst_n = 1'b0; #1;
    n_tests++;
    if (clk_o !== 4'b0 || ce_o !== 4'b0 || upd_o !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_async: clk_o=%b ce_o=%b upd_o=%b required all 0", clk_o, ce_o, upd_o);
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    n_tests++;
    if (ce_o !== 4'b0001 || clk_o !== 4'b0001 || upd_o !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_first_edge: clk_o=%b ce_o=%b upd_o=%b required 0001 0001 0000", clk_o, ce_o, upd_o);
    end
  endtask

  task automatic test_ratios();
    logic [NUM_CH-1:0] ec, ee;
    en_i = '0;
    set_div(0, 4); set_div(1, 3); set_div(2, 1); set_div(3, 0);
    step();
    en_i = '1;
    for (int i = 0; i < 12; i++) begin
      step();
      ec = {1'b0, 1'b0, (i % 3) == 0, (i % 4) < 2};
      ee = {1'b1, 1'b1, (i % 3) == 0, (i % 4) == 0};
      n_tests++;
      if (clk_o !== ec || ce_o !== ee || upd_o !== 4'b0) begin
        n_fail++;
        $display("FAIL ratios[%0d]: clk_o=%b ce_o=%b upd_o=%b required %b %b 0000", i, clk_o, ce_o, upd_o, ec, ee);
      end
    end
  endtask

  task automatic test_div_update();
    logic [8:0] ec, ee, eu;
    ec = 9'b101000111;
    ee = 9'b101000001;
    eu = 9'b001000000;
    en_i = '0;
    set_div(0, 6);
    step();
    en_i = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 1) set_div(0, 2);
      n_tests++;
      if (clk_o[0] !== ec[i] || ce_o[0] !== ee[i] || upd_o[0] !== eu[i]) begin
        n_fail++;
        $display("FAIL div_update[%0d]: clk=%b ce=%b upd=%b required %b %b %b",
                 i, clk_o[0], ce_o[0], upd_o[0], ec[i], ee[i], eu[i]);
      end
    end
  endtask

  task automatic test_enable();
    en_i = '0;
    set_div(0, 8);
    step();
    en_i[0] = 1'b1;
    step();
    n_tests++;
    if (ce_o[0] !== 1'b1 || clk_o[0] !== 1'b1 || upd_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_first: clk=%b ce=%b upd=%b required 1 1 0", clk_o[0], ce_o[0], upd_o[0]);
    end
    step(); step();
    n_tests++;
    if (clk_o[0] !== 1'b1 || ce_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_cnt2: clk=%b ce=%b required 1 0", clk_o[0], ce_o[0]);
    end
    en_i[0] = 1'b0;
    step();
    n_tests++;
    if (clk_o[0] !== 1'b0 || ce_o[0] !== 1'b0 || upd_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable: clk=%b ce=%b upd=%b required 0 0 0", clk_o[0], ce_o[0], upd_o[0]);
    end
    set_div(0, 3);
    en_i[0] = 1'b1;
    step();
    n_tests++;
    if (clk_o[0] !== 1'b1 || ce_o[0] !== 1'b1 || upd_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reenable: clk=%b ce=%b upd=%b required 1 1 0", clk_o[0], ce_o[0], upd_o[0]);
    end
  endtask

  task automatic test_sync();
    int nce;
    en_i = '0;
    set_div(0, 5); set_div(1, 7);
    step();
    en_i = 4'b0011;
    step(); step(); step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    n_tests++;
    if (ce_o[1:0] !== 2'b11 || clk_o[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL sync_align: ce=%b clk=%b required 11 11", ce_o[1:0], clk_o[1:0]);
    end
    nce = 0;
    for (int j = 1; j <= 9; j++) begin
      if (j == 5) sync_i = 1'b1;
      step();
      sync_i = 1'b0;
      if (ce_o[0] === 1'b1) nce++;
      if (j == 5) begin
        n_tests++;
        if (ce_o[1:0] !== 2'b11 || upd_o[1:0] !== 2'b00) begin
          n_fail++;
          $display("FAIL sync_coincident: ce=%b upd=%b required 11 00", ce_o[1:0], upd_o[1:0]);
        end
      end
    end
    n_tests++;
    if (nce != 1) begin
      n_fail++;
      $display("FAIL sync_single_wrap: ce count=%0d required 1", nce);
    end
  endtask

  // Reference model: each channel tracks the period it is in (length and
  // position) and whether it was running; outputs follow from those.
  task automatic test_random();
    int  per[NUM_CH];
    int  pos[NUM_CH];
    bit  run[NUM_CH];
    bit  pen[NUM_CH];
    int  d;
    logic [NUM_CH-1:0] ec, ee, eu;
    logic [DIV_W-1:0] dv;
    en_i = '0; sync_i = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      per[c] = 1; pos[c] = 0; run[c] = 0; pen[c] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 15) == 0)
          set_div(c, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9));
        if ($urandom_range(0, 47) == 0) en_i[c] = ~en_i[c];
      end
      sync_i = ($urandom_range(0, 49) == 0);
      step();
      for (int c = 0; c < NUM_CH; c++) begin
        dv = div_i[c*DIV_W +: DIV_W];
        d  = (dv == 0) ? 1 : int'(dv);
        ec[c] = 1'b0; ee[c] = 1'b0; eu[c] = 1'b0;
        if (!en_i[c]) begin
          run[c] = 0;
        end else if (!run[c] || sync_i || pos[c] == per[c] - 1) begin
          eu[c]  = pen[c] && run[c] && (d != per[c]);
          ee[c]  = 1'b1;
          per[c] = d; pos[c] = 0; run[c] = 1;
          ec[c]  = (0 < d / 2);
        end else begin
          pos[c] = pos[c] + 1;
          ec[c]  = (pos[c] < per[c] / 2);
        end
        pen[c] = en_i[c];
      end
      sync_i = 1'b0;
      n_tests++;
      if (clk_o !== ec || ce_o !== ee || upd_o !== eu) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL random[%0d]: clk_o=%b ce_o=%b upd_o=%b required %b %b %b",
                   cyc, clk_o, ce_o, upd_o, ec, ee, eu);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ratios();
    test_div_update();
    test_enable();
    test_sync();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
